multiport_memory: RTL and testbench

//   Parametrised multi-read/multi-write synchronous data memory shared by the cores of the

---
 rtl/multiport_memory.sv | 133 +++++++++++++
 tb/tb_multiport_memory.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_memory.sv
// Multi-read/multi-write synchronous data memory with per-byte write enables,
// lowest-index-wins write arbitration, selectable read-during-write behaviour
// and a post-reset clear sweep.
module multiport_memory #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 11,
    parameter int unsigned DEPTH          = 2048,
    parameter int unsigned NUM_RD         = 3,
    parameter int unsigned NUM_WR         = 2,
    parameter int unsigned WRITE_THROUGH  = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_WR-1:0]            w_en,
    input  logic [NUM_WR*DATA_W/8-1:0]   w_be,
    input  logic [NUM_WR*ADDR_W-1:0]     w_adrs,
    input  logic [NUM_WR*DATA_W-1:0]     data_in,
    output logic [NUM_WR-1:0]            w_valid,
    input  logic [NUM_RD-1:0]            r_en,
    input  logic [NUM_RD*ADDR_W-1:0]     r_adrs,
    output logic [NUM_RD*DATA_W-1:0]     data_out,
    output logic [NUM_RD-1:0]            r_valid,
    output logic                         init_busy
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADRS = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_adrs;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [NUM_WR-1:0] wr_ok;
    logic [NUM_WR-1:0] win;
    logic [DATA_W-1:0] rd_word [NUM_RD];

    // Write arbitration: in-range requests, lowest index wins on a shared address
    always_comb begin
        wr_ok = '0;
        win   = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_ok[k] = w_en[k] && (32'(w_adrs[k*ADDR_W +: ADDR_W]) < DEPTH);
        end
        for (int k = 0; k < NUM_WR; k++) begin
            win[k] = wr_ok[k];
            for (int j = 0; j < NUM_WR; j++) begin
                if (j < k && wr_ok[j] &&
                    w_adrs[j*ADDR_W +: ADDR_W] == w_adrs[k*ADDR_W +: ADDR_W]) begin
                    win[k] = 1'b0;
                end
            end
        end
    end

    // Read word per port; optionally forwards the winning write's enabled bytes
    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            rd_word[r] = '0;
            if (32'(r_adrs[r*ADDR_W +: ADDR_W]) < DEPTH) begin
                rd_word[r] = mem[IDX_W'(r_adrs[r*ADDR_W +: ADDR_W])];
                if (WRITE_THROUGH != 0) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (win[k] && w_adrs[k*ADDR_W +: ADDR_W] == r_adrs[r*ADDR_W +: ADDR_W]) begin
                            for (int b = 0; b < BYTES; b++) begin
                                if (w_be[k*BYTES + b]) begin
                                    rd_word[r][b*8 +: 8] = data_in[k*DATA_W + b*8 +: 8];
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    // Control FSM: clear sweep, then registered read data and valids
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_adrs  <= '0;
            init_busy <= (CLEAR_ON_RESET != 0);
            w_valid   <= '0;
            r_valid   <= '0;
            data_out  <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    w_valid <= '0;
                    r_valid <= '0;
                    if (clr_adrs == LAST_ADRS) begin
                        state     <= IDLE;
                        init_busy <= 1'b0;
                    end else begin
                        clr_adrs <= clr_adrs + ADDR_W'(1);
                    end
                end
                default: begin
                    w_valid <= win;
                    r_valid <= r_en;
                    for (int r = 0; r < NUM_RD; r++) begin
                        if (r_en[r]) begin
                            data_out[r*DATA_W +: DATA_W] <= rd_word[r];
                        end
                    end
                end
            endcase
        end
    end

    // Storage array: sweep zeroes one word per cycle, otherwise byte-masked winning writes
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[IDX_W'(clr_adrs)] <= '0;
            end else begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (win[k]) begin
                        for (int b = 0; b < BYTES; b++) begin
                            if (w_be[k*BYTES + b]) begin
                                mem[IDX_W'(w_adrs[k*ADDR_W +: ADDR_W])][b*8 +: 8] <=
                                    data_in[k*DATA_W + b*8 +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multiport_memory.sv
// Self-checking bench for multiport_memory: two instances (read-old and
// write-through) share stimulus; a reference model queues expected outputs.
module tb_multiport_memory;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   w_en;
    logic [7:0]   w_be;
    logic [9:0]   w_adrs;
    logic [63:0]  data_in;
    logic [2:0]   r_en;
    logic [14:0]  r_adrs;

    logic [1:0]   wv0, wv1;
    logic [95:0]  d0, d1;
    logic [2:0]   rv0, rv1;
    logic         busy0, busy1;

    logic [31:0]  mdl [16];
    logic [95:0]  lastd0, lastd1;
    logic [201:0] sb [$];

    int checks = 0;
    int passed = 0;

    multiport_memory #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .NUM_RD(3), .NUM_WR(2),
                       .WRITE_THROUGH(0), .CLEAR_ON_RESET(1)) u_dut_ro (
        .clk(clk), .reset(reset), .w_en(w_en), .w_be(w_be), .w_adrs(w_adrs),
        .data_in(data_in), .w_valid(wv0), .r_en(r_en), .r_adrs(r_adrs),
        .data_out(d0), .r_valid(rv0), .init_busy(busy0));

    multiport_memory #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .NUM_RD(3), .NUM_WR(2),
                       .WRITE_THROUGH(1), .CLEAR_ON_RESET(1)) u_dut_wt (
        .clk(clk), .reset(reset), .w_en(w_en), .w_be(w_be), .w_adrs(w_adrs),
        .data_in(data_in), .w_valid(wv1), .r_en(r_en), .r_adrs(r_adrs),
        .data_out(d1), .r_valid(rv1), .init_busy(busy1));

    initial forever #5 clk = ~clk;

    task automatic clear_in();
        w_en = '0; w_be = '0; w_adrs = '0; data_in = '0; r_en = '0; r_adrs = '0;
    endtask

    task automatic set_wr(input int k, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] be);
        w_en[k] = 1'b1;
        w_adrs[k*5 +: 5] = a;
        data_in[k*32 +: 32] = d;
        w_be[k*4 +: 4] = be;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        r_en[k] = 1'b1;
        r_adrs[k*5 +: 5] = a;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        lastd0 = '0;
        lastd1 = '0;
    endtask

    // Model the current inputs, queue the expected outputs, advance one clock
    task automatic step();
        logic [31:0] post [16];
        logic [1:0]  ok, win;
        logic [4:0]  a;
        post = mdl;
        for (int k = 0; k < 2; k++) begin
            a = w_adrs[k*5 +: 5];
            ok[k] = w_en[k] && (a < 5'd16);
        end
        for (int k = 0; k < 2; k++) begin
            win[k] = ok[k];
            for (int j = 0; j < 2; j++)
                if (j < k && ok[j] && w_adrs[j*5 +: 5] == w_adrs[k*5 +: 5]) win[k] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            if (win[k]) begin
                a = w_adrs[k*5 +: 5];
                for (int by = 0; by < 4; by++)
                    if (w_be[k*4 + by]) post[a[3:0]][by*8 +: 8] = data_in[k*32 + by*8 +: 8];
            end
        end
        for (int r = 0; r < 3; r++) begin
            if (r_en[r]) begin
                a = r_adrs[r*5 +: 5];
                lastd0[r*32 +: 32] = (a < 5'd16) ? mdl[a[3:0]] : 32'd0;
                lastd1[r*32 +: 32] = (a < 5'd16) ? post[a[3:0]] : 32'd0;
            end
        end
        sb.push_back({win, win, r_en, r_en, lastd0, lastd1});
        mdl = post;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [201:0] e, o;
        int n;
        reset = 1'b1;
        clear_in();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy0, busy1, wv0, wv1, rv0, rv1, d0, d1} !== {2'b11, 202'd0})
            $display("FAIL reset_state: got %h want %h",
                     {busy0, busy1, wv0, wv1, rv0, rv1, d0, d1}, {2'b11, 202'd0});
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 16 || busy1 !== 1'b0)
            $display("FAIL clear_length: got %0d cycles (busy_wt=%b) want 16 cycles", n, busy1);
        else passed++;
        model_clear();
        for (int i = 0; i < 6; i++) begin
            clear_in();
            for (int r = 0; r < 3; r++)
                if (i*3 + r < 16) set_rd(r, 5'(i*3 + r));
            step();
            e = sb.pop_front();
            o = {wv0, wv1, rv0, rv1, d0, d1};
            checks++;
            if (o !== e) $display("FAIL clear_readback: got %h want %h", o, e);
            else passed++;
        end
        clear_in();
    endtask

    task automatic test_byte_enable();
        logic [201:0] e, o;
        for (int i = 0; i < 3; i++) begin
            clear_in();
            case (i)
                0: set_wr(0, 5'd5, 32'hDEADBEEF, 4'b1111);
                1: set_wr(0, 5'd5, 32'h00001234, 4'b0011);
                default: set_rd(0, 5'd5);
            endcase
            step();
            e = sb.pop_front();
            o = {wv0, wv1, rv0, rv1, d0, d1};
            checks++;
            if (o !== e) $display("FAIL byte_enable: got %h want %h", o, e);
            else passed++;
        end
        checks++;
        if (d0[31:0] !== 32'hDEAD1234 || rv0[0] !== 1'b1)
            $display("FAIL byte_enable_word: got %h/%b want deadbeef merged deadbeef->dead1234/1",
                     d0[31:0], rv0[0]);
        else passed++;
        clear_in();
    endtask

    task automatic test_collision();
        logic [201:0] e, o;
        clear_in();
        set_wr(0, 5'd7, 32'h11111111, 4'hF);
        set_wr(1, 5'd7, 32'h22222222, 4'hF);
        step();
        checks++;
        if (wv0 !== 2'b01 || wv1 !== 2'b01)
            $display("FAIL collision_valid: got %b/%b want 01", wv0, wv1);
        else passed++;
        e = sb.pop_front();
        o = {wv0, wv1, rv0, rv1, d0, d1};
        checks++;
        if (o !== e) $display("FAIL collision: got %h want %h", o, e);
        else passed++;
        clear_in();
        set_rd(1, 5'd7);
        step();
        e = sb.pop_front();
        o = {wv0, wv1, rv0, rv1, d0, d1};
        checks++;
        if (o !== e || d0[63:32] !== 32'h11111111)
            $display("FAIL collision_read: got %h want %h", o, e);
        else passed++;
        clear_in();
    endtask

    task automatic test_read_during_write();
        logic [201:0] e, o;
        for (int i = 0; i < 3; i++) begin
            clear_in();
            case (i)
                0: set_wr(0, 5'd3, 32'hAAAA0000, 4'hF);
                1: begin set_wr(0, 5'd3, 32'h5555FFFF, 4'hF); set_rd(2, 5'd3); end
                default: begin set_wr(1, 5'd3, 32'h00770000, 4'b0100); set_rd(2, 5'd3); end
            endcase
            step();
            e = sb.pop_front();
            o = {wv0, wv1, rv0, rv1, d0, d1};
            checks++;
            if (o !== e) $display("FAIL read_during_write: got %h want %h", o, e);
            else passed++;
            if (i == 1) begin
                checks++;
                if (d0[95:64] !== 32'hAAAA0000 || d1[95:64] !== 32'h5555FFFF)
                    $display("FAIL rdw_words: got %h/%h want aaaa0000/5555ffff",
                             d0[95:64], d1[95:64]);
                else passed++;
            end
        end
        clear_in();
    endtask

    task automatic test_out_of_range();
        logic [201:0] e, o;
        clear_in();
        set_rd(0, 5'd16);
        set_wr(1, 5'd17, 32'hCAFEF00D, 4'hF);
        set_wr(0, 5'd2, 32'h12345678, 4'b0000);
        step();
        checks++;
        if (d0[31:0] !== 32'd0 || rv0[0] !== 1'b1 || wv0 !== 2'b01)
            $display("FAIL out_of_range: got data %h rv %b wv %b want 0/1/01",
                     d0[31:0], rv0[0], wv0);
        else passed++;
        e = sb.pop_front();
        o = {wv0, wv1, rv0, rv1, d0, d1};
        checks++;
        if (o !== e) $display("FAIL out_of_range_all: got %h want %h", o, e);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            clear_in();
            for (int r = 0; r < 3; r++)
                if (i*3 + r < 16) set_rd(r, 5'(i*3 + r));
            step();
            e = sb.pop_front();
            o = {wv0, wv1, rv0, rv1, d0, d1};
            checks++;
            if (o !== e) $display("FAIL out_of_range_sweep: got %h want %h", o, e);
            else passed++;
        end
        clear_in();
    endtask

    task automatic test_back_to_back();
        logic [201:0] e, o;
        logic [4:0]   a;
        for (int i = 0; i < 60; i++) begin
            clear_in();
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    a = ($urandom_range(0, 7) == 0) ? 5'(16 + $urandom_range(0, 1))
                                                    : 5'($urandom_range(0, 9));
                    set_wr(k, a, $urandom, 4'($urandom_range(0, 15)));
                end
            end
            if ($urandom_range(0, 3) == 0) w_adrs[9:5] = w_adrs[4:0];
            for (int r = 0; r < 3; r++) begin
                if ($urandom_range(0, 2) != 0) begin
                    a = ($urandom_range(0, 7) == 0) ? 5'(16 + $urandom_range(0, 1))
                                                    : 5'($urandom_range(0, 9));
                    set_rd(r, a);
                end
            end
            step();
            e = sb.pop_front();
            o = {wv0, wv1, rv0, rv1, d0, d1};
            checks++;
            if (o !== e) $display("FAIL back_to_back[%0d]: got %h want %h", i, o, e);
            else passed++;
        end
        clear_in();
    endtask

    task automatic test_reset_mid_sweep();
        logic [201:0] e, o;
        int n;
        logic bad;
        clear_in();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy0, busy1, wv0, wv1, rv0, rv1, d0, d1} !== {2'b11, 202'd0})
            $display("FAIL mid_sweep_reset_state: got %h want %h",
                     {busy0, busy1, wv0, wv1, rv0, rv1, d0, d1}, {2'b11, 202'd0});
        else passed++;
        #1;
        reset = 1'b0;
        set_wr(0, 5'd4, 32'hFFFFFFFF, 4'hF);
        set_rd(1, 5'd4);
        n = 0;
        bad = 1'b0;
        while (busy0 === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (wv0 !== 2'b00 || wv1 !== 2'b00 || rv0 !== 3'b000 || rv1 !== 3'b000) bad = 1'b1;
        end
        clear_in();
        checks++;
        if (n !== 16) $display("FAIL sweep_restart: got %0d busy cycles want 16", n);
        else passed++;
        checks++;
        if (bad !== 1'b0) $display("FAIL busy_ignore: got valid pulse %b want 0", bad);
        else passed++;
        model_clear();
        set_rd(1, 5'd4);
        set_rd(2, 5'd9);
        step();
        e = sb.pop_front();
        o = {wv0, wv1, rv0, rv1, d0, d1};
        checks++;
        if (o !== e) $display("FAIL after_restart_read: got %h want %h", o, e);
        else passed++;
        clear_in();
    endtask

    initial begin
        clear_in();
        reset = 1'b1;
        test_reset();
        test_byte_enable();
        test_collision();
        test_read_during_write();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
